mem_port_arbiter: RTL

Arbiter and sequencer that shares one variable-latency memory port between the instruction-fetch stage and the memory-access stage of the five-stage pipeline. It issues at most one outstanding transaction and routes the response back to the right requester. It raises per-stage stall requests for the hazard controller and drops stale fetch responses after a branch/address fix. It sits between `fetch`/`memory_access` and the external memory bus.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter_starve_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the memory-port arbiter.
//   - arb_state_e : sequencer states
//   - MEM_ADDR_W / MEM_DATA_W : default bus widths
//   - mem_cmd_t   : bus command bundle (we, addr, wstrb, wdata) at default widths
package mem_bus_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2,
    IF_DROP = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                    we;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W/8-1:0] wstrb;
    logic [MEM_DATA_W-1:0]   wdata;
  } mem_cmd_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: external memory bus.
//   master (arbiter): drives mem_req/we/addr/wstrb/wdata, receives gnt/rvalid/rdata
//   slave  (memory) : the reverse
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: saturating up-counter with synchronous clear.
//   clk, rst (async active-low), clr (wins over inc), inc, cnt (saturates at MAX)
module starve_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                          cnt_d = '0;
    else if (inc && cnt_q != W'(MAX)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between
// instruction fetch (if_*) and memory access (d_*). One outstanding
// transaction at a time; responses are steered back to the owner.
//   clk, rst        : clock, async active-low reset
//   if_req/addr/kill: fetch request, kill discards the in-flight fetch
//   if_rvalid/rdata : fetch response pulse
//   d_req/we/addr/wstrb/wdata, d_rvalid/rdata : load/store request/response
//   if_stall/d_stall: stall requests to hazard control
//   mem             : external bus (master side)
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                if_stall,
  output logic                d_stall,
  mem_port_arbiter_if.master  mem
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  // Same layout as mem_cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   wdata;
  } cmd_t;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_if, pick_d, grant_if, grant_d, is_idle;
  logic             req_c;
  cmd_t             cmd_c;

  // Data (older instruction) wins by default; fetch wins when data is idle
  // or fetch has waited STARVE_MAX data grants. A killed fetch never wins.
  assign is_idle  = (state_q == IDLE);
  assign pick_if  = if_req & ~if_kill & ((starve_cnt == CNT_W'(STARVE_MAX)) | ~d_req);
  assign pick_d   = d_req & ~pick_if;
  assign grant_if = is_idle & pick_if & mem.mem_gnt;
  assign grant_d  = is_idle & pick_d  & mem.mem_gnt;

  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    cmd_c     = '0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_if) begin
          req_c      = 1'b1;
          cmd_c.addr = if_addr;
        end else if (pick_d) begin
          req_c = 1'b1;
          cmd_c = '{we: d_we, addr: d_addr, wstrb: d_wstrb, wdata: d_wdata};
        end
        if (grant_if)     state_d = IF_WAIT;
        else if (grant_d) state_d = D_WAIT;
      end
      IF_WAIT: begin
        if (mem.mem_rvalid) begin
          if_rvalid = ~if_kill;   // kill coinciding with the response drops it
          state_d   = IDLE;
        end else if (if_kill) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: if (mem.mem_rvalid) state_d = IDLE;
      D_WAIT: begin
        if (mem.mem_rvalid) begin
          d_rvalid = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  starve_counter #(.MAX(STARVE_MAX), .W(CNT_W)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (~if_req | grant_if),
    .inc (grant_d & if_req),
    .cnt (starve_cnt)
  );

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = cmd_c.we;
  assign mem.mem_addr  = cmd_c.addr;
  assign mem.mem_wstrb = cmd_c.wstrb;
  assign mem.mem_wdata = cmd_c.wdata;

  // Read data is zero outside the response pulse.
  assign if_rdata = if_rvalid ? mem.mem_rdata : '0;
  assign d_rdata  = d_rvalid  ? mem.mem_rdata : '0;
  assign if_stall = if_req & ~if_rvalid;
  assign d_stall  = d_req  & ~d_rvalid;
endmodule
